lzc_denorm_seq: RTL
===================

Name: lzc_denorm_seq

Overview:
- Multi-cycle inverse of the 32-bit leading-zero counter. It takes a normalized 32-bit value plus its leading-zero count Z and all-zero flag AZ, and reconstructs the original operand as a logical right shift by Z.
- The shift is iterative, one binary stage per cycle (16, 8, 4, 2, 1), behind valid/ready handshakes on both sides.
- It sits downstream of the normalize path: LZC32 produces Z, a left shifter normalizes, and this block undoes the normalization.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- ZW, 5, count width (log2 WIDTH); fixed to 5.
- CHECK_NORM, 1, when 1 the block flags non-normalized input (bit 31 clear while AZ=0) on err; when 0, err is tied 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand.
- norm_din  input  32  normalized value (MSB expected 1 unless az).
- z  input  5  leading-zero count to restore.
- az  input  1  original operand was all zeros.
- out_valid  output  1  dout/err valid.
- out_ready  input  1  consumer accepts the result.
- dout  output  32  reconstructed value.
- err  output  1  input was not normalized (CHECK_NORM=1 only).

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears in_ready, out_valid, dout and err to 0, the stage counter to 0, and the shift/count registers to 0. In IDLE with reset released, in_ready=1.
- Reset mid-operation aborts the operation with no output. After release the block is in IDLE with in_ready=1.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept edge E0 (in_valid & in_ready): load sh <= az ? 0 : norm_din, zr <= z, err_r <= CHECK_NORM & ~az & ~norm_din[31], stage counter cnt <= 0. Go to SHIFT.
  - in_ready is 0 in SHIFT and DONE, so no new accept occurs there.
- SHIFT (cnt 0..4):
  - Each edge applies one stage: if zr[4-cnt] then sh <= sh >> (16 >> cnt), else sh holds. Shifts are logical and zero-fill.
  - cnt increments. At the edge with cnt==4, go to DONE.
  - All five stages always run, so latency is fixed regardless of z or az.
- DONE:
  - out_valid=1, dout=sh, err=err_r. These are held stable until out_ready.
  - Edge with out_valid & out_ready: go to IDLE, out_valid drops to 0, in_ready rises.
  - There is no same-cycle accept on the completion edge.
- Timing:
  - Operand accepted at edge E0; out_valid is high after edge E5.
  - Minimum issue interval is 7 cycles with out_ready held high.
- Inputs are sampled only at the accept edge; changes to norm_din, z or az afterwards have no effect.
- Boundaries:
  - z=0: dout=norm_din.
  - z=31: dout=norm_din>>31 (1 for a normalized input).
  - az=1: dout=0 and err=0 regardless of norm_din and z.
  - A non-normalized input is still shifted and reported with err=1; dout is norm_din>>z.
- out_ready held low keeps DONE indefinitely with outputs unchanged.
- out_ready may be high before out_valid; it has no effect outside DONE.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT with z=5'd9 -> out_valid=0 and dout=0 immediately (asynchronous). After release, in_ready=1 and no stale result ever appears.
- Round trip: norm_din=32'h8000_0000, z=31, az=0 -> dout=32'h0000_0001, err=0, out_valid high exactly 5 edges after accept. Also norm_din=32'hB400_0000, z=4 -> dout=32'h0B40_0000.
- All-zero: az=1, norm_din=32'hFFFF_FFFF, z=7 -> dout=32'h0000_0000, err=0, same 5-cycle latency.
- Non-normalized, CHECK_NORM=1: norm_din=32'h4000_0000, z=2, az=0 -> dout=32'h1000_0000, err=1. Rerun with CHECK_NORM=0 -> err=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> dout and err stable, in_ready=0. Raise out_ready -> one transfer, next cycle in_ready=1. A second in_valid held throughout is accepted only then.
- Randomized: 1000 operands from a reference chain (x -> LZC Z/AZ -> x<<Z) -> dout==x for every nonzero x, dout==0 for x=0, err=0 always.

Source files
------------

// File: rtl/lzc_denorm_seq_if.sv
// Handshake bundle for lzc_denorm_seq: operand side (in_*) and result side (out_*).
interface lzc_denorm_seq_if #(
    parameter int WIDTH = 32,
    parameter int ZW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] norm_din;
    logic [ZW-1:0]    z;
    logic             az;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             err;

    modport master (
        output in_valid, norm_din, z, az, out_ready,
        input  in_ready, out_valid, dout, err
    );

    modport slave (
        input  in_valid, norm_din, z, az, out_ready,
        output in_ready, out_valid, dout, err
    );
endinterface

// File: rtl/lzc_denorm_seq.sv
// Undoes LZC normalization: logical right shift of norm_din by z, one binary
// stage (16, 8, 4, 2, 1) per cycle, with valid/ready on both sides.
module lzc_denorm_seq #(
    parameter int WIDTH      = 32,
    parameter int ZW         = 5,
    parameter bit CHECK_NORM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    lzc_denorm_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [ZW-1:0]    zr;
    logic [ZW-1:0]    stage_w;
    logic [2:0]       cnt;
    logic             err_r;

    // Stage weight 16>>cnt is also the zr bit mask that selects this stage.
    always_comb begin
        stage_w = 5'd16 >> cnt;
        sh_next = sh;
        if (|(zr & stage_w)) begin
            sh_next = sh >> stage_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.dout      <= '0;
            bus.err       <= 1'b0;
            cnt           <= '0;
            sh            <= '0;
            zr            <= '0;
            err_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sh           <= bus.az ? '0 : bus.norm_din;
                        zr           <= bus.z;
                        err_r        <= CHECK_NORM && !bus.az && !bus.norm_din[WIDTH-1];
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= SHIFT;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    sh  <= sh_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        // Result register takes the final stage directly so it is valid on entry to DONE.
                        bus.out_valid <= 1'b1;
                        bus.dout      <= sh_next;
                        bus.err       <= err_r;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
